// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the ID-stage hazard controller: forwarding codes and FSM states.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Operand source selected in ID
  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,  // register file read data
    FWD_EALU = 2'd1,  // EX-stage ALU result
    FWD_MALU = 2'd2,  // MEM-stage ALU result
    FWD_MMO  = 2'd3   // MEM-stage load data
  } fwd_t;

  // Front-end sequencing state
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_IO_WAIT  = 2'd1,
    ST_IO_ABORT = 2'd2
  } hz_state_t;

  // Source select for one operand. EX is younger than MEM, so it wins. An EX load
  // cannot forward (its data does not exist yet); load-use stalls cover that case.
  function automatic fwd_t fwd_sel(
    input logic [4:0] r,
    input logic       use_r,
    input logic [4:0] e_rn,
    input logic       e_wreg,
    input logic       e_m2reg,
    input logic [4:0] m_rn,
    input logic       m_wreg,
    input logic       m_m2reg
  );
    fwd_sel = FWD_RF;
    if (use_r && (r != 5'd0)) begin
      if (e_wreg && (e_rn == r) && !e_m2reg) begin
        fwd_sel = FWD_EALU;
      end else if (m_wreg && (m_rn == r)) begin
        fwd_sel = m_m2reg ? FWD_MMO : FWD_MALU;
      end
    end
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard bundle between the pipeline datapath and the hazard controller.
// Latency: n/a (wires only).
// Backpressure: wpcir/dbubble/e_kill are the stall and flush controls to the front end.
interface pipe_hazard_ctrl_if;

  // Instruction in ID
  logic [4:0] rs;
  logic [4:0] rt;
  logic       use_rs;
  logic       use_rt;
  logic       branch_taken;
  logic       io_req;
  logic       io_ready;

  // Older instructions in EX and MEM
  logic [4:0] e_rn;
  logic       e_wreg;
  logic       e_m2reg;
  logic [4:0] m_rn;
  logic       m_wreg;
  logic       m_m2reg;

  // Controls back to the datapath
  logic       wpcir;
  logic       dbubble;
  logic       e_kill;
  logic [1:0] fwda;
  logic [1:0] fwdb;
  logic       io_timeout;

  // Datapath side
  modport master (
    output rs, rt, use_rs, use_rt, branch_taken, io_req, io_ready,
    output e_rn, e_wreg, e_m2reg, m_rn, m_wreg, m_m2reg,
    input  wpcir, dbubble, e_kill, fwda, fwdb, io_timeout
  );

  // Controller side
  modport slave (
    input  rs, rt, use_rs, use_rt, branch_taken, io_req, io_ready,
    input  e_rn, e_wreg, e_m2reg, m_rn, m_wreg, m_m2reg,
    output wpcir, dbubble, e_kill, fwda, fwdb, io_timeout
  );

endinterface

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding select for rs/rt plus load-use hazard detection.
// Latency: purely combinational, 0 cycles.
// Backpressure: none here; lu is consumed by the controller FSM to stall.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       use_rs,
  input  logic       use_rt,
  input  logic [4:0] e_rn,
  input  logic       e_wreg,
  input  logic       e_m2reg,
  input  logic [4:0] m_rn,
  input  logic       m_wreg,
  input  logic       m_m2reg,
  output fwd_t       fwda,
  output fwd_t       fwdb,
  output logic       lu
);

  // Per-operand source select, same rule for both operands
  assign fwda = fwd_sel(rs, use_rs, e_rn, e_wreg, e_m2reg, m_rn, m_wreg, m_m2reg);
  assign fwdb = fwd_sel(rt, use_rt, e_rn, e_wreg, e_m2reg, m_rn, m_wreg, m_m2reg);

  // Load in EX whose result a used ID source needs: one bubble lets it reach MEM
  assign lu = e_wreg && e_m2reg && (e_rn != 5'd0) &&
              ((use_rs && (e_rn == rs)) || (use_rt && (e_rn == rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard controller: load-use stall, branch flush, forwarding, slow-I/O hold with timeout.
// Latency: stall/flush/forward controls are combinational from ID inputs and the registered state.
// Backpressure: wpcir=0 holds PC and IF/ID; e_kill bubbles ID/EX; IO_WAIT holds until io_ready or abort.
// Optional PIPE_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int IO_TIMEOUT = 255,
  parameter int CNT_W      = 8,
  parameter int PERF_W     = 32
) (
  input  logic              clock,
  input  logic              resetn,
  pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  // Last counter value allowed in IO_WAIT before the access is abandoned
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(IO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Reject configurations where the timeout cannot be reached by the counter
  if ((IO_TIMEOUT < 1) || (IO_TIMEOUT > (2**CNT_W) - 1) || (PERF_W < 1)) begin : g_param_chk
    $error("pipe_hazard_ctrl: IO_TIMEOUT must be 1..2^CNT_W-1 and PERF_W >= 1");
  end

  hz_state_t        state;
  logic [CNT_W-1:0] wait_cnt;
  logic             io_timeout_q;
  logic             lu;
  fwd_t             fwda;
  fwd_t             fwdb;
  logic             wpcir_c;
  logic             dbubble_c;
  logic             e_kill_c;

  pipe_fwd_unit u_fwd (
    .rs      (hz.rs),
    .rt      (hz.rt),
    .use_rs  (hz.use_rs),
    .use_rt  (hz.use_rt),
    .e_rn    (hz.e_rn),
    .e_wreg  (hz.e_wreg),
    .e_m2reg (hz.e_m2reg),
    .m_rn    (hz.m_rn),
    .m_wreg  (hz.m_wreg),
    .m_m2reg (hz.m_m2reg),
    .fwda    (fwda),
    .fwdb    (fwdb),
    .lu      (lu)
  );

  // Sequencing FSM with wait counter; io_timeout is registered on entry to IO_ABORT
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_RUN;
      wait_cnt     <= '0;
      io_timeout_q <= 1'b0;
    end else begin
      io_timeout_q <= 1'b0;
      case (state)
        ST_RUN: begin
          // Load-use outranks the I/O request; the I/O access is retried next cycle
          if (!lu && hz.io_req) begin
            state    <= ST_IO_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_IO_WAIT: begin
          if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
          // A device answering on the last allowed cycle still completes the access
          if (hz.io_ready) begin
            state <= ST_RUN;
          end else if (wait_cnt == TO_LAST) begin
            state        <= ST_IO_ABORT;
            io_timeout_q <= 1'b1;
          end
        end
        ST_IO_ABORT: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  // Front-end controls decoded from state and the current ID-stage hazards
  always_comb begin
    wpcir_c   = 1'b1;
    dbubble_c = 1'b0;
    e_kill_c  = 1'b0;
    case (state)
      ST_RUN: begin
        if (lu || hz.io_req) begin
          // Hold ID; branch outcome is not trusted while stalled
          wpcir_c  = 1'b0;
          e_kill_c = 1'b1;
        end else if (hz.branch_taken) begin
          dbubble_c = 1'b1;
        end
      end
      ST_IO_WAIT: begin
        // On io_ready the held access issues into EX this cycle
        if (!hz.io_ready) begin
          wpcir_c  = 1'b0;
          e_kill_c = 1'b1;
        end
      end
      ST_IO_ABORT: begin
        // Drop the failed access and the instruction fetched behind it
        dbubble_c = 1'b1;
        e_kill_c  = 1'b1;
      end
      default: begin
        wpcir_c = 1'b1;
      end
    endcase
  end

  assign hz.wpcir      = wpcir_c;
  assign hz.dbubble    = dbubble_c;
  assign hz.e_kill     = e_kill_c;
  assign hz.fwda       = fwda;
  assign hz.fwdb       = fwdb;
  assign hz.io_timeout = io_timeout_q;

`ifdef PIPE_PERF_CNT_EN
  // Cycle counts of front-end stalls and IF/ID flushes; wrap at max
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!wpcir_c) begin
        stall_cnt <= stall_cnt + PERF_W'(1);
      end
      if (dbubble_c) begin
        flush_cnt <= flush_cnt + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, branch flush, I/O wait/timeout, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
// ctl below packs {wpcir, dbubble, e_kill, io_timeout}.
module tb_pipe_hazard_ctrl;

  logic clock;
  logic resetn;
  int   checks;
  int   fails;

  pipe_hazard_ctrl_if hz ();

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  pipe_hazard_ctrl #(
    .IO_TIMEOUT (4),
    .CNT_W      (8),
    .PERF_W     (32)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .hz     (hz)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  logic [3:0] ctl;
  assign ctl = {hz.wpcir, hz.dbubble, hz.e_kill, hz.io_timeout};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    hz.rs = 5'd0; hz.rt = 5'd0; hz.use_rs = 1'b0; hz.use_rt = 1'b0;
    hz.branch_taken = 1'b0; hz.io_req = 1'b0; hz.io_ready = 1'b0;
    hz.e_rn = 5'd0; hz.e_wreg = 1'b0; hz.e_m2reg = 1'b0;
    hz.m_rn = 5'd0; hz.m_wreg = 1'b0; hz.m_m2reg = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle();
    #2;
    checks++; if (ctl !== 4'b1000) begin $display("FAIL reset_ctl got=%b exp=%b", ctl, 4'b1000); fails++; end
    checks++; if ({hz.fwda, hz.fwdb} !== 4'b0000) begin $display("FAIL reset_fwd got=%b exp=%b", {hz.fwda, hz.fwdb}, 4'b0000); fails++; end
`ifdef PIPE_PERF_CNT_EN
    checks++; if ({stall_cnt, flush_cnt} !== 64'd0) begin $display("FAIL reset_perf got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); fails++; end
`endif
    @(posedge clock);
    #1 resetn = 1'b1;
    step();
  endtask

  task automatic test_load_use();
    idle();
    hz.e_rn = 5'd3; hz.e_wreg = 1'b1; hz.e_m2reg = 1'b1;
    hz.rs = 5'd3; hz.use_rs = 1'b1; hz.rt = 5'd7; hz.use_rt = 1'b1;
    #1;
    checks++; if (ctl !== 4'b0010) begin $display("FAIL lu_rs_stall got=%b exp=%b", ctl, 4'b0010); fails++; end
    checks++; if (hz.fwda !== 2'd0) begin $display("FAIL lu_rs_fwda got=%0d exp=0", hz.fwda); fails++; end
    step();
    // Load moved to MEM, bubble in EX
    hz.e_rn = 5'd0; hz.e_wreg = 1'b0; hz.e_m2reg = 1'b0;
    hz.m_rn = 5'd3; hz.m_wreg = 1'b1; hz.m_m2reg = 1'b1;
    #1;
    checks++; if (ctl !== 4'b1000) begin $display("FAIL lu_release got=%b exp=%b", ctl, 4'b1000); fails++; end
    checks++; if (hz.fwda !== 2'd3) begin $display("FAIL lu_fwda_mmo got=%0d exp=3", hz.fwda); fails++; end
    step();
    idle();
    hz.e_rn = 5'd9; hz.e_wreg = 1'b1; hz.e_m2reg = 1'b1;
    hz.rs = 5'd1; hz.use_rs = 1'b1; hz.rt = 5'd9; hz.use_rt = 1'b1;
    #1;
    checks++; if (ctl !== 4'b0010) begin $display("FAIL lu_rt_stall got=%b exp=%b", ctl, 4'b0010); fails++; end
    step();
    hz.use_rt = 1'b0;
    #1;
    checks++; if (ctl !== 4'b1000) begin $display("FAIL lu_rt_unused got=%b exp=%b", ctl, 4'b1000); fails++; end
    step();
    idle();
    hz.e_rn = 5'd0; hz.e_wreg = 1'b1; hz.e_m2reg = 1'b1; hz.rs = 5'd0; hz.use_rs = 1'b1;
    #1;
    checks++; if (ctl !== 4'b1000) begin $display("FAIL lu_r0 got=%b exp=%b", ctl, 4'b1000); fails++; end
    step();
  endtask

  task automatic test_forward();
    idle();
    hz.e_rn = 5'd5; hz.e_wreg = 1'b1; hz.m_rn = 5'd5; hz.m_wreg = 1'b1;
    hz.rs = 5'd5; hz.use_rs = 1'b1;
    #1;
    checks++; if (hz.fwda !== 2'd1) begin $display("FAIL fwd_ex_wins got=%0d exp=1", hz.fwda); fails++; end
    hz.e_wreg = 1'b0;
    #1;
    checks++; if (hz.fwda !== 2'd2) begin $display("FAIL fwd_mem_alu got=%0d exp=2", hz.fwda); fails++; end
    hz.m_m2reg = 1'b1;
    #1;
    checks++; if (hz.fwda !== 2'd3) begin $display("FAIL fwd_mem_load got=%0d exp=3", hz.fwda); fails++; end
    step();
    idle();
    hz.e_rn = 5'd0; hz.e_wreg = 1'b1; hz.m_rn = 5'd0; hz.m_wreg = 1'b1;
    hz.rs = 5'd0; hz.use_rs = 1'b1;
    #1;
    checks++; if (hz.fwda !== 2'd0) begin $display("FAIL fwd_r0 got=%0d exp=0", hz.fwda); fails++; end
    idle();
    hz.e_rn = 5'd5; hz.e_wreg = 1'b1; hz.rt = 5'd5; hz.use_rt = 1'b0;
    #1;
    checks++; if (hz.fwdb !== 2'd0) begin $display("FAIL fwdb_unused got=%0d exp=0", hz.fwdb); fails++; end
    hz.use_rt = 1'b1;
    #1;
    checks++; if ({hz.fwda, hz.fwdb} !== 4'b0001) begin $display("FAIL fwdb_ex got=%b exp=%b", {hz.fwda, hz.fwdb}, 4'b0001); fails++; end
    step();
  endtask

  task automatic test_branch();
    idle();
    hz.branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== 4'b1100) begin $display("FAIL br_flush got=%b exp=%b", ctl, 4'b1100); fails++; end
    step();
    hz.e_rn = 5'd3; hz.e_wreg = 1'b1; hz.e_m2reg = 1'b1; hz.rs = 5'd3; hz.use_rs = 1'b1;
    #1;
    checks++; if (ctl !== 4'b0010) begin $display("FAIL br_under_lu got=%b exp=%b", ctl, 4'b0010); fails++; end
    step();
    idle();
  endtask

  task automatic test_io_ready();
    idle();
    hz.io_req = 1'b1;
    #1;
    checks++; if (ctl !== 4'b0010) begin $display("FAIL io_enter got=%b exp=%b", ctl, 4'b0010); fails++; end
    step();
    #1;
    checks++; if (ctl !== 4'b0010) begin $display("FAIL io_wait0 got=%b exp=%b", ctl, 4'b0010); fails++; end
    step();
    #1;
    checks++; if (ctl !== 4'b0010) begin $display("FAIL io_wait1 got=%b exp=%b", ctl, 4'b0010); fails++; end
    step();
    hz.io_ready = 1'b1;
    #1;
    checks++; if (ctl !== 4'b1000) begin $display("FAIL io_ready_issue got=%b exp=%b", ctl, 4'b1000); fails++; end
    step();
    idle();
    hz.branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== 4'b1100) begin $display("FAIL io_back_run got=%b exp=%b", ctl, 4'b1100); fails++; end
    step();
    idle();
  endtask

  task automatic test_io_ready_at_limit();
    idle();
    hz.io_req = 1'b1;
    step();
    hz.io_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== 4'b0010) begin $display("FAIL limit_wait%0d got=%b exp=%b", i, ctl, 4'b0010); fails++; end
      step();
    end
    hz.io_ready = 1'b1;
    #1;
    checks++; if (ctl !== 4'b1000) begin $display("FAIL limit_ready got=%b exp=%b", ctl, 4'b1000); fails++; end
    step();
    hz.io_ready = 1'b0;
    #1;
    checks++; if (ctl !== 4'b1000) begin $display("FAIL limit_no_abort got=%b exp=%b", ctl, 4'b1000); fails++; end
    step();
  endtask

  task automatic test_io_timeout();
    int lows;
    bit seen;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] s0;
    logic [31:0] f0;
    s0 = stall_cnt;
    f0 = flush_cnt;
`endif
    idle();
    hz.io_req = 1'b1;
    #1;
    checks++; if (ctl !== 4'b0010) begin $display("FAIL to_enter got=%b exp=%b", ctl, 4'b0010); fails++; end
    step();
    hz.io_req = 1'b0;
    lows = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (hz.wpcir === 1'b0) lows++;
      else seen = 1'b1;
      if (!seen) step();
    end
    checks++; if (seen !== 1'b1) begin $display("FAIL to_bound got=no_release exp=release"); fails++; end
    checks++; if (lows !== 4) begin $display("FAIL to_wait_cycles got=%0d exp=4", lows); fails++; end
    checks++; if (ctl !== 4'b1111) begin $display("FAIL to_abort got=%b exp=%b", ctl, 4'b1111); fails++; end
    step();
    checks++; if (ctl !== 4'b1000) begin $display("FAIL to_pulse_end got=%b exp=%b", ctl, 4'b1000); fails++; end
`ifdef PIPE_PERF_CNT_EN
    checks++; if ((stall_cnt - s0) !== 32'd5) begin $display("FAIL to_perf_stall got=%0d exp=5", stall_cnt - s0); fails++; end
    checks++; if ((flush_cnt - f0) !== 32'd1) begin $display("FAIL to_perf_flush got=%0d exp=1", flush_cnt - f0); fails++; end
`endif
    hz.branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== 4'b1100) begin $display("FAIL to_back_run got=%b exp=%b", ctl, 4'b1100); fails++; end
    step();
    idle();
  endtask

  task automatic test_reset_mid_wait();
    int pulses;
    idle();
    hz.io_req = 1'b1;
    step();
    hz.io_req = 1'b0;
    step();
    resetn = 1'b0;
    #1;
    checks++; if (ctl !== 4'b1000) begin $display("FAIL rst_mid_ctl got=%b exp=%b", ctl, 4'b1000); fails++; end
`ifdef PIPE_PERF_CNT_EN
    checks++; if ({stall_cnt, flush_cnt} !== 64'd0) begin $display("FAIL rst_mid_perf got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); fails++; end
`endif
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (hz.io_timeout !== 1'b0) pulses++;
    end
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (hz.io_timeout !== 1'b0) pulses++;
    end
    checks++; if (pulses !== 0) begin $display("FAIL rst_no_pulse got=%0d exp=0", pulses); fails++; end
    hz.branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== 4'b1100) begin $display("FAIL rst_run got=%b exp=%b", ctl, 4'b1100); fails++; end
    step();
    idle();
  endtask

  task automatic test_back_to_back();
    idle();
    hz.e_rn = 5'd4; hz.e_wreg = 1'b1; hz.e_m2reg = 1'b1;
    hz.rt = 5'd4; hz.use_rt = 1'b1; hz.io_req = 1'b1;
    #1;
    checks++; if (ctl !== 4'b0010) begin $display("FAIL b2b_lu_first got=%b exp=%b", ctl, 4'b0010); fails++; end
    step();
    idle();
    hz.branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== 4'b1100) begin $display("FAIL b2b_stayed_run got=%b exp=%b", ctl, 4'b1100); fails++; end
    step();
    idle();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_io_ready();
    test_io_ready_at_limit();
    test_io_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
